aes_dram_cmd_sequencer: RTL
===========================

// Module: aes_dram_cmd_sequencer
// PURPOSE
// - Byte-stream command sequencer between the UART byte link and the AES_DRAM_Top core.
// - Assembles 128-bit key and plaintext words from received bytes and drives the core's KDRDY/EN handshakes.
// - Waits for Kvld/Dvld, then serialises Dout back as 16 bytes.
// - Owns core reset (RSTN_AES), core power-up hold and protocol error reporting.
// PARAMETERS
// - CMD_KEY      8'h4B  command byte: load key (16 payload bytes follow)
// - CMD_ENC      8'h45  command byte: encrypt (16 payload bytes follow)
// - RST_HOLD     4      cycles RSTN_AES held low after RST deasserts (>=1)
// - TIMEOUT_CYC  4096   watchdog limit in cycles (used only with AES_SEQ_TIMEOUT_EN)
// PORTS
// - CLK        in   1    system clock (buffered differential clock)
// - RST        in   1    asynchronous, active-high reset
// - RX_DATA    in   8    received byte
// - RX_VLD     in   1    1-cycle strobe: RX_DATA valid; no backpressure, bytes arriving outside IDLE/RX_* are dropped
// - TX_DATA    out  8    byte to transmit
// - TX_VLD     out  1    TX_DATA valid; held with TX_DATA stable until TX_RDY
// - TX_RDY     in   1    transmitter accepts byte when TX_VLD&TX_RDY
// - KIN_AES    out  128  key to core
// - DIN_AES    out  128  plaintext to core
// - KDRDY_AES  out  1    1-cycle key-load strobe
// - EN_AES     out  1    1-cycle encrypt-start strobe
// - RSTN_AES   out  1    active-low core reset
// - BSY_AES    in   1    core busy
// - KVLD_AES   in   1    key expansion done (pulse)
// - DVLD_AES   in   1    ciphertext valid (pulse)
// - DOUT_AES   in   128  ciphertext
// - KEY_LOADED out  1    a key has been accepted since last reset/abort
// - ERR        out  1    1-cycle pulse on any protocol error
// BEHAVIOUR
// - Reset values: TX_VLD=0, TX_DATA=0, KIN/DIN=0, KDRDY/EN=0, KEY_LOADED=0, ERR=0, RSTN_AES=0, state=IDLE.
// - RSTN_AES rises exactly RST_HOLD cycles after the first CLK edge with RST low.
// - RX bytes are ignored until RSTN_AES=1.
// - Byte order: first payload byte -> [127:120]; last -> [7:0]. TX sends DOUT[127:120] first.
// - Payload is shifted into a 128-bit register with a 4-bit counter; the 16th byte ends RX_KEY/RX_PT.
// - IDLE:
//   - RX byte==CMD_KEY -> RX_KEY.
//   - RX byte==CMD_ENC -> RX_PT.
//   - Any other byte -> ERR pulse, stay IDLE.
// - RX_KEY: 16 bytes -> KIN_AES updated -> KEY_REQ.
// - KEY_REQ: wait BSY_AES=0; then KDRDY_AES=1 for 1 cycle -> KEY_WAIT.
// - KEY_WAIT: on KVLD_AES -> KEY_LOADED=1, queue ack byte 8'h06 -> TX_ACK.
// - RX_PT: 16 bytes -> DIN_AES updated.
//   - If KEY_LOADED=0: queue 8'hEE, ERR pulse -> TX_ACK.
//   - Otherwise -> ENC_REQ.
// - ENC_REQ: wait BSY_AES=0; then EN_AES=1 for 1 cycle -> ENC_WAIT.
// - ENC_WAIT: on DVLD_AES -> capture DOUT_AES into TX shift register -> TX_CT.
// - TX_CT: present 16 bytes; advance on each TX_VLD&TX_RDY; after 16th -> IDLE.
// - TX_ACK: present 1 byte; on TX_VLD&TX_RDY -> IDLE.
// - Latency: KDRDY/EN asserted 1 cycle after the 16th RX_VLD when BSY_AES=0.
// - TX_VLD asserted the cycle after DVLD_AES/KVLD_AES.
// - Simultaneous events:
//   - KVLD_AES/DVLD_AES outside its WAIT state is ignored.
//   - RX_VLD in the same cycle as a state exit to IDLE is dropped.
//   - TX_RDY held high gives 1 byte/cycle.
// - Reset mid-operation: any state -> IDLE immediately.
//   - Partial payload and pending TX are discarded; KEY_LOADED cleared; RSTN_AES re-holds RST_HOLD cycles.
// CONFIGURATION
// - AES_SEQ_TIMEOUT_EN defined:
//   - A 16-bit watchdog counts cycles in KEY_REQ/KEY_WAIT/ENC_REQ/ENC_WAIT.
//   - At TIMEOUT_CYC: RSTN_AES low for RST_HOLD cycles, KEY_LOADED=0, ERR pulse, queue 8'hEE -> TX_ACK.
// - AES_SEQ_TIMEOUT_EN undefined: no watchdog; WAIT states wait indefinitely; TIMEOUT_CYC unused.
// TESTING
// - Reset release -> RSTN_AES=0 for 4 cycles then 1; all other outputs at reset values.
// - Key load: 4B + bytes 00..0F, core mock asserts KVLD 10 cycles after KDRDY
//   -> KIN=128'h000102..0F, one KDRDY pulse, TX 8'h06, KEY_LOADED=1.
// - Encrypt: after key, 45 + 16 bytes, mock DOUT=128'h69C4E0D86A7B0430D8CDB78070B4C55A with DVLD
//   -> one EN pulse, TX 69,C4,...,5A in order.
// - Encrypt without key: 45 + 16 bytes -> no EN pulse, TX 8'hEE, ERR pulse.
// - Bad command 8'h00 in IDLE -> ERR pulse, no TX.
// - TX backpressure: TX_RDY toggled randomly -> all 16 bytes sent in order.
// - BSY_AES=1 before the 16th byte -> EN waits until BSY=0.
// - RST mid-RX_PT (8th byte) -> IDLE; next full 45-sequence returns 8'hEE.
// - With AES_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64, mock never asserts DVLD
//   -> after 64 cycles: RSTN_AES low 4 cycles, TX 8'hEE, KEY_LOADED=0.

Source files
------------

// File: rtl/aes_dram_cmd_sequencer_if.sv
// Byte-link and AES core signal bundle for aes_dram_cmd_sequencer.
// master = sequencer side, slave = link/core side.
interface aes_dram_cmd_sequencer_if;
  logic [7:0]   RX_DATA;
  logic         RX_VLD;
  logic [7:0]   TX_DATA;
  logic         TX_VLD;
  logic         TX_RDY;
  logic [127:0] KIN_AES;
  logic [127:0] DIN_AES;
  logic         KDRDY_AES;
  logic         EN_AES;
  logic         RSTN_AES;
  logic         BSY_AES;
  logic         KVLD_AES;
  logic         DVLD_AES;
  logic [127:0] DOUT_AES;
  logic         KEY_LOADED;
  logic         ERR;

  modport master (
    input  RX_DATA, RX_VLD, TX_RDY,
    input  BSY_AES, KVLD_AES, DVLD_AES, DOUT_AES,
    output TX_DATA, TX_VLD,
    output KIN_AES, DIN_AES, KDRDY_AES, EN_AES,
    output RSTN_AES, KEY_LOADED, ERR
  );

  modport slave (
    output RX_DATA, RX_VLD, TX_RDY,
    output BSY_AES, KVLD_AES, DVLD_AES, DOUT_AES,
    input  TX_DATA, TX_VLD,
    input  KIN_AES, DIN_AES, KDRDY_AES, EN_AES,
    input  RSTN_AES, KEY_LOADED, ERR
  );
endinterface

// File: rtl/aes_dram_cmd_sequencer.sv
// UART byte-stream command sequencer for the AES_DRAM_Top core.
// Optional watchdog: define AES_SEQ_TIMEOUT_EN.
module aes_dram_cmd_sequencer #(
  parameter logic [7:0] CMD_KEY = 8'h4B,
  parameter logic [7:0] CMD_ENC = 8'h45,
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic CLK,
  input logic RST,
  aes_dram_cmd_sequencer_if.master io
);

  typedef enum logic [3:0] {
    IDLE, RX_KEY, KEY_REQ, KEY_WAIT,
    RX_PT, ENC_REQ, ENC_WAIT, TX_CT, TX_ACK
  } state_t;

  state_t state_q, state_d;
  logic [7:0]   hold_q, hold_d;
  logic         rstn_q, rstn_d;
  logic [127:0] sh_q, sh_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] kin_q, kin_d;
  logic [127:0] din_q, din_d;
  logic         kdrdy_q, kdrdy_d;
  logic         en_q, en_d;
  logic         tx_vld_q, tx_vld_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         key_q, key_d;
  logic         err_q, err_d;
`ifdef AES_SEQ_TIMEOUT_EN
  logic [15:0]  wd_q, wd_d;
`endif

  logic         rx_ok;
  logic         tx_acc;
  logic [127:0] rx_word;

  assign rx_ok   = io.RX_VLD & rstn_q;
  assign tx_acc  = tx_vld_q & io.TX_RDY;
  assign rx_word = {sh_q[119:0], io.RX_DATA};

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rstn_d    = rstn_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    kin_d     = kin_q;
    din_d     = din_q;
    kdrdy_d   = 1'b0;
    en_d      = 1'b0;
    tx_vld_d  = tx_vld_q;
    tx_data_d = tx_data_q;
    key_d     = key_q;
    err_d     = 1'b0;

    if (!rstn_q) begin
      hold_d = hold_q + 8'd1;
      rstn_d = (hold_q == 8'(RST_HOLD));
    end

    unique case (state_q)
      IDLE: begin
        if (rx_ok) begin
          cnt_d = 4'd0;
          if (io.RX_DATA == CMD_KEY)
            state_d = RX_KEY;
          else if (io.RX_DATA == CMD_ENC)
            state_d = RX_PT;
          else
            err_d = 1'b1;
        end
      end
      RX_KEY: begin
        if (rx_ok) begin
          sh_d  = rx_word;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'hF) begin
            kin_d = rx_word;
            if (!io.BSY_AES) begin
              kdrdy_d = 1'b1;
              state_d = KEY_WAIT;
            end else begin
              state_d = KEY_REQ;
            end
          end
        end
      end
      KEY_REQ: begin
        if (!io.BSY_AES) begin
          kdrdy_d = 1'b1;
          state_d = KEY_WAIT;
        end
      end
      KEY_WAIT: begin
        if (io.KVLD_AES) begin
          key_d     = 1'b1;
          tx_data_d = 8'h06;
          tx_vld_d  = 1'b1;
          state_d   = TX_ACK;
        end
      end
      RX_PT: begin
        if (rx_ok) begin
          sh_d  = rx_word;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'hF) begin
            din_d = rx_word;
            if (!key_q) begin
              tx_data_d = 8'hEE;
              tx_vld_d  = 1'b1;
              err_d     = 1'b1;
              state_d   = TX_ACK;
            end else if (!io.BSY_AES) begin
              en_d    = 1'b1;
              state_d = ENC_WAIT;
            end else begin
              state_d = ENC_REQ;
            end
          end
        end
      end
      ENC_REQ: begin
        if (!io.BSY_AES) begin
          en_d    = 1'b1;
          state_d = ENC_WAIT;
        end
      end
      ENC_WAIT: begin
        if (io.DVLD_AES) begin
          tx_data_d = io.DOUT_AES[127:120];
          sh_d      = {io.DOUT_AES[119:0], 8'h00};
          cnt_d     = 4'd0;
          tx_vld_d  = 1'b1;
          state_d   = TX_CT;
        end
      end
      TX_CT: begin
        if (tx_acc) begin
          cnt_d     = cnt_q + 4'd1;
          tx_data_d = sh_q[127:120];
          sh_d      = {sh_q[119:0], 8'h00};
          if (cnt_q == 4'hF) begin
            tx_vld_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      TX_ACK: begin
        if (tx_acc) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AES_SEQ_TIMEOUT_EN
    wd_d = 16'd0;
    if (state_q inside {KEY_REQ, KEY_WAIT, ENC_REQ, ENC_WAIT}) begin
      wd_d = wd_q + 16'd1;
      if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
        wd_d      = 16'd0;
        hold_d    = 8'd1;
        rstn_d    = 1'b0;
        key_d     = 1'b0;
        err_d     = 1'b1;
        kdrdy_d   = 1'b0;
        en_d      = 1'b0;
        tx_data_d = 8'hEE;
        tx_vld_d  = 1'b1;
        state_d   = TX_ACK;
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      rstn_q    <= 1'b0;
      sh_q      <= '0;
      cnt_q     <= 4'd0;
      kin_q     <= '0;
      din_q     <= '0;
      kdrdy_q   <= 1'b0;
      en_q      <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= 8'h00;
      key_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      wd_q      <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rstn_q    <= rstn_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      kin_q     <= kin_d;
      din_q     <= din_d;
      kdrdy_q   <= kdrdy_d;
      en_q      <= en_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      key_q     <= key_d;
      err_q     <= err_d;
`ifdef AES_SEQ_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign io.TX_DATA    = tx_data_q;
  assign io.TX_VLD     = tx_vld_q;
  assign io.KIN_AES    = kin_q;
  assign io.DIN_AES    = din_q;
  assign io.KDRDY_AES  = kdrdy_q;
  assign io.EN_AES     = en_q;
  assign io.RSTN_AES   = rstn_q;
  assign io.KEY_LOADED = key_q;
  assign io.ERR        = err_q;

endmodule
